mac_pe: RTL and testbench
=========================

# mac_pe

Parametrised systolic processing element; successor to the single-width 32-bit MAC cell. Accepts one A/B operand pair per cycle under a valid/ready handshake and forwards A east and B south, one cycle later, to neighbouring PEs. Accumulates signed or unsigned products over a vector delimited by `last` flags, then presents the dot product on a held result port with its own valid/ready handshake. Tiles into the systolic array grid.

## Interface
- `DATA_W`, 16: operand width.
- `ACC_W`, 40: accumulator and result width; must be ≥ 2·DATA_W.
- `SIGNED`, 1: 1 gives two's-complement operands; 0 gives unsigned.
- `SATURATE`, 0: 1 clamps on overflow; 0 wraps modulo 2^ACC_W.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `a_in`, `b_in` in DATA_W: operands.
- `in_valid` in 1: the operand pair is valid.
- `a_last`, `b_last` in 1: the pair is the final element of the vector.
- `in_ready` out 1: the pair is accepted when `in_valid & in_ready`.
- `a_out`, `b_out` out DATA_W: forwarded operands.
- `fwd_valid` out 1: `a_out`/`b_out` valid.
- `fwd_last` out 1: forwarded last flag (`a_last | b_last`).
- `c_out` out ACC_W: result.
- `c_valid` out 1: result valid.
- `c_ready` in 1: result consumed on `c_valid & c_ready`.
- `c_ovf` out 1: the result overflowed the accumulator (qualified by `c_valid`).
- `err` out 1: sticky flag for a last-flag mismatch.

## Operation
- Stage 1 (accept): on an accepted pair, register the full-precision product (2·DATA_W, signed or unsigned per `SIGNED`) and `last`. Register `a_in`/`b_in` into `a_out`/`b_out`.
- Stage 2 (accumulate): `acc <= acc + sext/zext(product)`.
  - When the stage-1 `last` is set, load `acc + product` into `c_out`, set `c_valid`, and clear `acc` to 0 in the same cycle.
- Overflow is tracked per vector. When the signed (or unsigned) sum exceeds ACC_W:
  - `SATURATE=1`: clamp to max/min (unsigned: max or 0).
  - `SATURATE=0`: wrap.
  - In either mode, `c_ovf` is set with the result; the per-vector ovf bit clears when the result loads.
- A pair with `a_last != b_last` sets `err` (sticky until `rst`) and is treated as last.
- `in_ready = !(c_valid & !c_ready) & !(s1_valid & s1_last)`. This is combinational from `c_ready` and guarantees stage 2 never finds the result slot occupied.
- State (package enum): IDLE (acc=0, no products since the last result) → ACCUM on the first accepted non-last pair.
  - ACCUM → IDLE when a last product retires.
  - IDLE → IDLE on a single-element vector.
- `c_valid` clears the cycle after the `c_valid & c_ready` handshake unless a new result loads in that same cycle. A new load has priority and keeps `c_valid` high.
- Reset mid-vector discards stage 1, `acc`, and the pending result.

## Timing
- Reset values: `in_ready`=1, `fwd_valid`=0, `fwd_last`=0, `a_out`=`b_out`=0, `c_out`=0, `c_valid`=0, `c_ovf`=0, `err`=0. Internal state: `acc`=0, state IDLE.
- Forward latency is 1 cycle: a pair accepted at cycle N appears on `a_out`/`b_out` with `fwd_valid`=1 at N+1. `fwd_valid`=0 in cycles with no accept.
- Result latency is 2 cycles: last accepted at N gives `c_valid`=1 at N+2. `in_ready`=0 at N+1.
- `c_out`/`c_ovf` hold stable while `c_valid & !c_ready`.
- Throughput: one pair per cycle within a vector; one bubble between vectors.

## Structure
- Package `mac_pkg`: `pe_state_t` enum (IDLE, ACCUM) and a width-check localparam helper.
- Sub-module `mac_sat_add`, combinational: inputs ACC_W accumulator, 2·DATA_W product, SIGNED, SATURATE; outputs sum and ovf.
- Elaboration assertion fires if `ACC_W < 2*DATA_W`.

## Test plan
Unless stated, DATA_W=16, ACC_W=40, SIGNED=1, SATURATE=0.
- Reset: hold `rst` for 2 cycles → all outputs at their reset values; `in_ready`=1.
- Vector a=[1,2,3,4], b=[5,6,7,8], `last` on the 4th pair, `c_ready`=1 → `c_out`=70 with `c_valid` 2 cycles after the last accept. `a_out` sequence is 1,2,3,4, each 1 cycle after its accept.
- Signed single-element vector, a=-3, b=7 → `c_out`=0xFF_FFFF_FFEB (-21), `c_ovf`=0.
- ACC_W=32, three pairs of 32767·32767:
  - `SATURATE=1` → `c_out`=0x7FFFFFFF, `c_ovf`=1.
  - `SATURATE=0` → `c_out`=-1073938429, `c_ovf`=1.
- Backpressure: result pending with `c_ready`=0 for 5 cycles → `in_ready`=0, `c_out` stable, next vector stalls. A `c_ready` pulse drains the result; the next result is then correct.
- Pair with `a_last`=1, `b_last`=0 → `err`=1 and the result is emitted. A `rst` assertion while the vector is in ACCUM → `acc` cleared; the next vector [2]×[3] gives 6.

Source files
------------

// File: rtl/mac_pe_pkg.sv
// Shared types and elaboration helpers for the systolic MAC processing element.
package mac_pkg;

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } pe_state_t;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 40;

    // The accumulator must hold at least one full-precision product.
    function automatic bit acc_w_ok(input int unsigned acc_w, input int unsigned data_w);
        return acc_w >= 2 * data_w;
    endfunction

endpackage

// File: rtl/mac_pe_sat_add.sv
// Accumulator adder: extends the product to accumulator width, adds, and
// reports overflow; optionally clamps the sum to the representable range.
module mac_sat_add #(
    parameter int unsigned ACC_W    = 40,
    parameter int unsigned PROD_W   = 32,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0] w_acc_x;
    logic [ACC_W:0] w_prod_x;
    logic [ACC_W:0] w_sum_x;
    logic           w_ovf;

    always_comb begin
        if (SIGNED) begin
            w_acc_x  = {i_acc[ACC_W-1], i_acc};
            w_prod_x = {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};
        end else begin
            w_acc_x  = {1'b0, i_acc};
            w_prod_x = {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
        end
        w_sum_x = w_acc_x + w_prod_x;

        // One guard bit: signed overflow when it disagrees with the MSB,
        // unsigned overflow when it carries.
        if (SIGNED) begin
            w_ovf = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];
        end else begin
            w_ovf = w_sum_x[ACC_W];
        end

        o_sum = w_sum_x[ACC_W-1:0];
        if (SATURATE && w_ovf) begin
            if (SIGNED) begin
                o_sum = w_sum_x[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                       : {1'b0, {(ACC_W - 1){1'b1}}};
            end else begin
                o_sum = '1;
            end
        end
        o_ovf = w_ovf;
    end

endmodule

// File: rtl/mac_pe.sv
// Systolic MAC processing element: forwards A east / B south, accumulates
// products over last-delimited vectors and presents a held dot-product result.
module mac_pe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    input  logic              a_last,
    input  logic              b_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    output logic              fwd_last,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_valid,
    input  logic              c_ready,
    output logic              c_ovf,
    output logic              err
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    if (!acc_w_ok(ACC_W, DATA_W)) begin : g_width_check
        $error("mac_pe: ACC_W (%0d) must be at least 2*DATA_W (%0d)", ACC_W, PROD_W);
    end

    logic [DATA_W-1:0] r_a_out;
    logic [DATA_W-1:0] r_b_out;
    logic              r_fwd_valid;
    logic              r_fwd_last;
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [PROD_W-1:0] r_s1_prod;
    logic [ACC_W-1:0]  r_acc;
    logic              r_vec_ovf;
    logic [ACC_W-1:0]  r_c_out;
    logic              r_c_valid;
    logic              r_c_ovf;
    logic              r_err;
    pe_state_t         r_state;

    logic              w_accept;
    logic              w_last;
    logic              w_mismatch;
    logic [PROD_W-1:0] w_a_x;
    logic [PROD_W-1:0] w_b_x;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_acc_in;
    logic [ACC_W-1:0]  w_sum;
    logic              w_add_ovf;

    assign in_ready   = !(r_c_valid && !c_ready) && !(r_s1_valid && r_s1_last);
    assign w_accept   = in_valid && in_ready;
    assign w_mismatch = a_last ^ b_last;
    assign w_last     = a_last | b_last;

    // Operands extended to product width make the low PROD_W bits of a plain
    // multiply equal to the signed or unsigned full-precision product.
    always_comb begin
        if (SIGNED) begin
            w_a_x = {{DATA_W{a_in[DATA_W-1]}}, a_in};
            w_b_x = {{DATA_W{b_in[DATA_W-1]}}, b_in};
        end else begin
            w_a_x = {{DATA_W{1'b0}}, a_in};
            w_b_x = {{DATA_W{1'b0}}, b_in};
        end
    end

    assign w_prod   = w_a_x * w_b_x;
    assign w_acc_in = (r_state == ACCUM) ? r_acc : '0;

    mac_sat_add #(
        .ACC_W   (ACC_W),
        .PROD_W  (PROD_W),
        .SIGNED  (SIGNED),
        .SATURATE(SATURATE)
    ) u_add (
        .i_acc (w_acc_in),
        .i_prod(r_s1_prod),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_last  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_prod   <= '0;
            r_acc       <= '0;
            r_vec_ovf   <= 1'b0;
            r_c_out     <= '0;
            r_c_valid   <= 1'b0;
            r_c_ovf     <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= IDLE;
        end else begin
            r_fwd_valid <= w_accept;
            r_fwd_last  <= w_accept && w_last;
            r_s1_valid  <= w_accept;

            if (w_accept) begin
                r_a_out   <= a_in;
                r_b_out   <= b_in;
                r_s1_prod <= w_prod;
                r_s1_last <= w_last;
                if (w_mismatch) begin
                    r_err <= 1'b1;
                end
                if (!w_last) begin
                    r_state <= ACCUM;
                end
            end

            if (r_c_valid && c_ready) begin
                r_c_valid <= 1'b0;
            end

            // A retiring last product overrides the handshake clear above.
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_c_out   <= w_sum;
                    r_c_ovf   <= r_vec_ovf | w_add_ovf;
                    r_c_valid <= 1'b1;
                    r_acc     <= '0;
                    r_vec_ovf <= 1'b0;
                    r_state   <= IDLE;
                end else begin
                    r_acc     <= w_sum;
                    r_vec_ovf <= r_vec_ovf | w_add_ovf;
                end
            end
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign fwd_valid = r_fwd_valid;
    assign fwd_last  = r_fwd_last;
    assign c_out     = r_c_out;
    assign c_valid   = r_c_valid;
    assign c_ovf     = r_c_ovf;
    assign err       = r_err;

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: table vectors, hand sequences for latency,
// backpressure, saturation, last-mismatch and reset, then random vectors.
module tb_mac_pe;

    typedef int arr_t [8];
    typedef struct {
        arr_t        a;
        arr_t        b;
        int          n;
        logic [39:0] c;
        bit          ovf;
    } vec_t;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } fwd_t;
    typedef struct {
        logic [39:0] c;
        logic        ovf;
    } res_t;

    localparam longint MAXV = (64'sd1 <<< 39) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< 39);

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        in_valid;
    logic        a_last;
    logic        b_last;
    logic        c_ready;

    logic        in_ready, fwd_valid, fwd_last, c_valid, c_ovf, err;
    logic [15:0] a_out, b_out;
    logic [39:0] c_out;

    logic        in_ready_s, fwd_valid_s, fwd_last_s, c_valid_s, c_ovf_s, err_s;
    logic [15:0] a_out_s, b_out_s;
    logic [31:0] c_out_s;

    logic        in_ready_w, fwd_valid_w, fwd_last_w, c_valid_w, c_ovf_w, err_w;
    logic [15:0] a_out_w, b_out_w;
    logic [31:0] c_out_w;

    int   n_pass;
    int   n_total;
    bit   mon_en;
    bit   rnd_bp;
    fwd_t fwd_q[$];
    res_t exp_q[$];

    mac_pe #(.DATA_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .a_last(a_last), .b_last(b_last), .in_ready(in_ready), .a_out(a_out),
        .b_out(b_out), .fwd_valid(fwd_valid), .fwd_last(fwd_last), .c_out(c_out),
        .c_valid(c_valid), .c_ready(c_ready), .c_ovf(c_ovf), .err(err)
    );

    mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .a_last(a_last), .b_last(b_last), .in_ready(in_ready_s), .a_out(a_out_s),
        .b_out(b_out_s), .fwd_valid(fwd_valid_s), .fwd_last(fwd_last_s), .c_out(c_out_s),
        .c_valid(c_valid_s), .c_ready(c_ready), .c_ovf(c_ovf_s), .err(err_s)
    );

    mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .a_last(a_last), .b_last(b_last), .in_ready(in_ready_w), .a_out(a_out_w),
        .b_out(b_out_w), .fwd_valid(fwd_valid_w), .fwd_last(fwd_last_w), .c_out(c_out_w),
        .c_valid(c_valid_w), .c_ready(c_ready), .c_ovf(c_ovf_w), .err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_fail(input string nm);
        n_total++;
        $display("FAIL %s: event with no expectation or bound expired", nm);
    endtask

    // Reference: plain integer dot product, wrapped into 40-bit two's complement.
    function automatic void ref_dot(input arr_t a, input arr_t b, input int n,
                                    output logic [39:0] c, output bit ovf);
        longint s = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + longint'(a[i]) * longint'(b[i]);
            if (s > MAXV || s < MINV) begin
                ovf = 1'b1;
                s   = (s <<< 24) >>> 24;
            end
        end
        c = s[39:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (fwd_valid) begin
                if (fwd_q.size() == 0) begin
                    check_fail("fwd_spurious");
                end else begin
                    fwd_t f;
                    f = fwd_q.pop_front();
                    check("a_out", a_out, f.a);
                    check("b_out", b_out, f.b);
                    check("fwd_last", fwd_last, f.last);
                end
            end
            if (c_valid && c_ready) begin
                if (exp_q.size() == 0) begin
                    check_fail("c_spurious");
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("c_out", c_out, r.c);
                    check("c_ovf", c_ovf, r.ovf);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 c_ready = 1'($urandom_range(0, 1));
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_pair(input int a, input int b, input logic al, input logic bl);
        int unsigned guard = 0;
        a_in     = 16'(a);
        b_in     = 16'(b);
        a_last   = al;
        b_last   = bl;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_fail("accept_timeout");
        fwd_q.push_back('{16'(a), 16'(b), al | bl});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_last   = 1'b0;
        b_last   = 1'b0;
    endtask

    task automatic send_vector(input arr_t a, input arr_t b, input int n, input bit mism,
                               input logic [39:0] ec, input bit eo, input bit chk);
        exp_q.push_back('{ec, eo});
        for (int i = 0; i < n; i++) begin
            send_pair(a[i], b[i], (i == n - 1), (i == n - 1) && !mism);
        end
        if (chk) begin
            @(negedge clk);
            check("in_ready_after_last", in_ready, 1'b0);
            check("c_valid_n1", c_valid, 1'b0);
            @(negedge clk);
            check("c_valid_n2", c_valid, 1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_results", exp_q.size(), 0);
        check("drain_fwd", fwd_q.size(), 0);
    endtask

    vec_t        tbl [5];
    arr_t        ra;
    arr_t        rb;
    arr_t        z;
    logic [39:0] ec;
    bit          eo;
    logic [31:0] exp_wrap;

    initial begin
        n_pass   = 0;
        n_total  = 0;
        mon_en   = 1'b0;
        rnd_bp   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        a_last   = 1'b0;
        b_last   = 1'b0;
        c_ready  = 1'b1;
        z        = '{0, 0, 0, 0, 0, 0, 0, 0};

        tbl[0] = '{'{1, 2, 3, 4, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0}, 4, 40'd70, 1'b0};
        tbl[1] = '{'{-3, 0, 0, 0, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0, 0, 0}, 1, 40'hFF_FFFF_FFEB, 1'b0};
        tbl[2] = '{'{2, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0}, 1, 40'd6, 1'b0};
        tbl[3] = '{'{-32768, 0, 0, 0, 0, 0, 0, 0}, '{-32768, 0, 0, 0, 0, 0, 0, 0}, 1, 40'h00_4000_0000, 1'b0};
        tbl[4] = '{'{32767, -32768, 100, 0, 0, 0, 0, 0}, '{-1, -1, -5, 0, 0, 0, 0, 0}, 3, 40'hFF_FFFF_FE0D, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_fwd_last", fwd_last, 1'b0);
        check("rst_a_out", a_out, 16'd0);
        check("rst_b_out", b_out, 16'd0);
        check("rst_c_out", c_out, 40'd0);
        check("rst_c_valid", c_valid, 1'b0);
        check("rst_c_ovf", c_ovf, 1'b0);
        check("rst_err", err, 1'b0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 5; t++) begin
            send_vector(tbl[t].a, tbl[t].b, tbl[t].n, 1'b0, tbl[t].c, tbl[t].ovf, 1'b1);
        end
        wait_drain();

        // Three 32767^2 products overflow a 32-bit signed accumulator.
        ra = '{32767, 32767, 32767, 0, 0, 0, 0, 0};
        ref_dot(ra, ra, 3, ec, eo);
        send_vector(ra, ra, 3, 1'b0, ec, eo, 1'b1);
        exp_wrap = 32'(64'd3 * 64'd1073676289);
        check("sat_c_out", c_out_s, 32'h7FFF_FFFF);
        check("sat_c_ovf", c_ovf_s, 1'b1);
        check("wrap_c_out", c_out_w, exp_wrap);
        check("wrap_c_ovf", c_ovf_w, 1'b1);
        wait_drain();

        // Backpressure: result held for 5 cycles while the next vector stalls.
        c_ready = 1'b0;
        ra = '{1, 1, 0, 0, 0, 0, 0, 0};
        send_vector(ra, ra, 2, 1'b0, 40'd2, 1'b0, 1'b0);
        fork
            begin
                rb = '{3, 0, 0, 0, 0, 0, 0, 0};
                ra = '{4, 0, 0, 0, 0, 0, 0, 0};
                send_vector(rb, ra, 1, 1'b0, 40'd12, 1'b0, 1'b0);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_c_valid", c_valid, 1'b1);
                    check("bp_c_out", c_out, 40'd2);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_fwd_valid", fwd_valid, 1'b0);
                end
                @(posedge clk);
                #1 c_ready = 1'b1;
            end
        join
        wait_drain();

        // Mismatched last flags end the vector and set the sticky error.
        ra = '{5, 0, 0, 0, 0, 0, 0, 0};
        send_vector(ra, ra, 1, 1'b1, 40'd25, 1'b0, 1'b1);
        check("err_set", err, 1'b1);
        wait_drain();

        // Reset while accumulating must discard the partial sum.
        send_pair(7, 7, 1'b0, 1'b0);
        send_pair(7, 7, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fwd_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst2_err", err, 1'b0);
        check("rst2_c_valid", c_valid, 1'b0);
        check("rst2_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        ra = '{2, 0, 0, 0, 0, 0, 0, 0};
        rb = '{3, 0, 0, 0, 0, 0, 0, 0};
        send_vector(ra, rb, 1, 1'b0, 40'd6, 1'b0, 1'b1);
        wait_drain();

        // Random vectors with random result backpressure.
        rnd_bp = 1'b1;
        for (int v = 0; v < 25; v++) begin
            int n;
            n  = int'($urandom_range(1, 6));
            ra = z;
            rb = z;
            for (int i = 0; i < n; i++) begin
                ra[i] = int'($urandom_range(0, 65535)) - 32768;
                rb[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            ref_dot(ra, rb, n, ec, eo);
            send_vector(ra, rb, n, 1'b0, ec, eo, 1'b0);
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #2 c_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
